// File: rtl/param_loader.sv
// Serialises parameter bytes, MSB first, onto the neuron parameter chain.
// Raises done once exactly CHAIN_BITS bits have been shifted; the last byte may be partial.
module param_loader #(
  parameter int NEURONS   = 8,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       setup,
  output logic       param_out,
  output logic       busy,
  output logic       done
);

  localparam int CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
  localparam int CW         = $clog2(CHAIN_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [CW-1:0] sent;
  logic [3:0]    nbits;
  logic [CW-1:0] remaining;
  logic [3:0]    byte_bits;

  always_comb begin
    remaining = CW'(CHAIN_BITS) - sent;
    byte_bits = 4'd8;
    if (int'(remaining) < 8) byte_bits = 4'(remaining);
  end

  // param_out is preloaded with the next bit so it is valid in every cycle setup is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      sent       <= '0;
      nbits      <= '0;
      data_ready <= 1'b0;
      setup      <= 1'b0;
      param_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            sent       <= '0;
            data_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        LOAD: begin
          if (data_valid) begin
            state      <= SHIFT;
            shreg      <= data_in;
            nbits      <= byte_bits;
            data_ready <= 1'b0;
            setup      <= 1'b1;
            param_out  <= data_in[7];
          end
        end
        SHIFT: begin
          shreg     <= {shreg[6:0], 1'b0};
          param_out <= shreg[6];
          sent      <= sent + CW'(1);
          nbits     <= nbits - 4'd1;
          if (nbits == 4'd1) begin
            setup     <= 1'b0;
            param_out <= 1'b0;
            if (sent == CW'(CHAIN_BITS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= LOAD;
              data_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader: a default 88-bit chain and a 3-neuron (33-bit) chain,
// each observed by a chain model that shifts param_out in whenever setup is high.
module tb_param_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, setup, param_out, busy, done;
  logic       data_ready3, setup3, param_out3, busy3, done3;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_loader dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .setup(setup), .param_out(param_out), .busy(busy), .done(done)
  );

  param_loader #(.NEURONS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready3), .setup(setup3), .param_out(param_out3), .busy(busy3), .done(done3)
  );

  // Chain models: the bit sampled first ends up at the MSB (far end of the chain).
  int          setup_cnt = 0, bursts = 0, setup_cnt3 = 0, bursts3 = 0;
  logic [87:0] chain = '0;
  logic [32:0] chain3 = '0;
  logic        prev_setup = 1'b0, prev_setup3 = 1'b0;

  always @(negedge clk) begin
    if (setup) begin
      setup_cnt++;
      chain = {chain[86:0], param_out};
      if (!prev_setup) bursts++;
    end
    prev_setup = setup;
    if (setup3) begin
      setup_cnt3++;
      chain3 = {chain3[31:0], param_out3};
      if (!prev_setup3) bursts3++;
    end
    prev_setup3 = setup3;
  end

  logic [7:0] bq [16];

  task automatic do_start(input bit sel);
    if (sel) start3 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((sel ? data_ready3 : data_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      data_in = b;
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      data_in = '0;
    end
  endtask

  task automatic wait_done(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ((sel ? done3 : done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({setup, data_ready, busy, done, param_out} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b expected 00000", {setup, data_ready, busy, done, param_out});
    end
    compared++;
    if ({setup3, data_ready3, busy3, done3, param_out3} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs3: got %b expected 00000", {setup3, data_ready3, busy3, done3, param_out3});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_load;
    int base, bb, t0;
    bit ok, all_ok;
    all_ok = 1'b1;
    base = setup_cnt;
    bb = bursts;
    do_start(1'b0);
    t0 = cyc;
    compared++;
    if ({busy, data_ready, done} !== 3'b110) begin
      mismatched++;
      $display("FAIL start_state: got %b expected 110", {busy, data_ready, done});
    end
    for (int i = 0; i < 11; i++) begin
      send_byte(1'b0, 8'hA5, ok);
      all_ok &= ok;
    end
    wait_done(1'b0, ok);
    all_ok &= ok;
    compared++;
    if (!all_ok) begin
      mismatched++;
      $display("FAIL full_handshake: got timeout expected completion");
    end
    compared++;
    if (setup_cnt - base != 88) begin
      mismatched++;
      $display("FAIL full_setup_cycles: got %0d expected 88", setup_cnt - base);
    end
    compared++;
    if (bursts - bb != 11) begin
      mismatched++;
      $display("FAIL full_bursts: got %0d expected 11", bursts - bb);
    end
    compared++;
    if (chain !== {11{8'hA5}}) begin
      mismatched++;
      $display("FAIL full_chain: got %h expected %h", chain, {11{8'hA5}});
    end
    compared++;
    if (cyc - t0 != 99) begin
      mismatched++;
      $display("FAIL full_latency: got %0d expected 99", cyc - t0);
    end
    compared++;
    if ({done, busy} !== 2'b10) begin
      mismatched++;
      $display("FAIL full_done_flags: got %b expected 10", {done, busy});
    end
    base = setup_cnt;
    data_in = 8'hFF;
    data_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 data_valid = 1'b0;
    data_in = '0;
    compared++;
    if (setup_cnt != base || {done, data_ready} !== 2'b10) begin
      mismatched++;
      $display("FAIL valid_in_done: got extra=%0d done/ready=%b expected 0 and 10",
               setup_cnt - base, {done, data_ready});
    end
  endtask

  task automatic test_partial;
    int base, t0, other;
    bit ok, all_ok;
    all_ok = 1'b1;
    base = setup_cnt3;
    other = setup_cnt;
    bq[0] = 8'h11; bq[1] = 8'h22; bq[2] = 8'h33; bq[3] = 8'h44; bq[4] = 8'h80;
    do_start(1'b1);
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b1, bq[i], ok);
      all_ok &= ok;
    end
    wait_done(1'b1, ok);
    all_ok &= ok;
    compared++;
    if (!all_ok) begin
      mismatched++;
      $display("FAIL partial_handshake: got timeout expected completion");
    end
    compared++;
    if (setup_cnt3 - base != 33) begin
      mismatched++;
      $display("FAIL partial_setup_cycles: got %0d expected 33", setup_cnt3 - base);
    end
    compared++;
    if (chain3 !== {8'h11, 8'h22, 8'h33, 8'h44, 1'b1}) begin
      mismatched++;
      $display("FAIL partial_chain: got %h expected %h", chain3, {8'h11, 8'h22, 8'h33, 8'h44, 1'b1});
    end
    compared++;
    if (cyc - t0 != 38) begin
      mismatched++;
      $display("FAIL partial_latency: got %0d expected 38", cyc - t0);
    end
    compared++;
    if (setup_cnt != other) begin
      mismatched++;
      $display("FAIL partial_other_idle: got %0d extra expected 0", setup_cnt - other);
    end
  endtask

  task automatic test_backpressure;
    int base, t0;
    bit ok, all_ok, stall_ok;
    logic [87:0] expv;
    all_ok = 1'b1;
    stall_ok = 1'b1;
    expv = '0;
    for (int i = 0; i < 11; i++) begin
      bq[i] = 8'h3C ^ 8'(i * 23);
      expv = {expv[79:0], bq[i]};
    end
    base = setup_cnt;
    do_start(1'b0);
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b0, bq[i], ok);
      all_ok &= ok;
    end
    for (int i = 0; i < 40 && data_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      if (setup !== 1'b0 || data_ready !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    compared++;
    if (!stall_ok) begin
      mismatched++;
      $display("FAIL stall_outputs: got setup/ready change expected setup=0 ready=1");
    end
    for (int i = 5; i < 11; i++) begin
      send_byte(1'b0, bq[i], ok);
      all_ok &= ok;
    end
    wait_done(1'b0, ok);
    all_ok &= ok;
    compared++;
    if (!all_ok) begin
      mismatched++;
      $display("FAIL stall_handshake: got timeout expected completion");
    end
    compared++;
    if (chain !== expv || setup_cnt - base != 88) begin
      mismatched++;
      $display("FAIL stall_chain: got %h/%0d expected %h/88", chain, setup_cnt - base, expv);
    end
    compared++;
    if (cyc - t0 != 119) begin
      mismatched++;
      $display("FAIL stall_latency: got %0d expected 119", cyc - t0);
    end
  endtask

  task automatic test_ignore_busy;
    int base, bb, t0;
    bit ok, all_ok;
    logic [87:0] expv;
    all_ok = 1'b1;
    expv = '0;
    for (int i = 0; i < 11; i++) begin
      bq[i] = 8'hC3 + 8'(i * 41);
      expv = {expv[79:0], bq[i]};
    end
    base = setup_cnt;
    bb = bursts;
    do_start(1'b0);
    t0 = cyc;
    for (int i = 0; i < 11; i++) begin
      send_byte(1'b0, bq[i], ok);
      all_ok &= ok;
      if (i == 3) begin
        start = 1'b1;
        data_valid = 1'b1;
        data_in = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        data_valid = 1'b0;
        data_in = '0;
        compared++;
        if ({busy, done, setup} !== 3'b101) begin
          mismatched++;
          $display("FAIL ignore_mid_flags: got %b expected 101", {busy, done, setup});
        end
      end
    end
    wait_done(1'b0, ok);
    all_ok &= ok;
    compared++;
    if (!all_ok) begin
      mismatched++;
      $display("FAIL ignore_handshake: got timeout expected completion");
    end
    compared++;
    if (chain !== expv || setup_cnt - base != 88 || bursts - bb != 11) begin
      mismatched++;
      $display("FAIL ignore_stream: got %h/%0d/%0d expected %h/88/11",
               chain, setup_cnt - base, bursts - bb, expv);
    end
    compared++;
    if (cyc - t0 != 99) begin
      mismatched++;
      $display("FAIL ignore_latency: got %0d expected 99", cyc - t0);
    end
  endtask

  task automatic test_reset_reload;
    int base;
    bit ok, all_ok;
    logic [87:0] expv;
    all_ok = 1'b1;
    base = setup_cnt;
    do_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b0, 8'h5A, ok);
      all_ok &= ok;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (setup_cnt - base >= 40) break;
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({setup, data_ready, busy, done, param_out} !== 5'b0) begin
      mismatched++;
      $display("FAIL midshift_reset: got %b expected 00000", {setup, data_ready, busy, done, param_out});
    end
    compared++;
    if (setup_cnt - base != 40) begin
      mismatched++;
      $display("FAIL midshift_bits: got %0d expected 40", setup_cnt - base);
    end
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({busy, data_ready, done, setup} !== 4'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: got %b expected 0000", {busy, data_ready, done, setup});
    end
    expv = '0;
    for (int i = 0; i < 11; i++) begin
      bq[i] = 8'h01 << (i % 8);
      expv = {expv[79:0], bq[i]};
    end
    base = setup_cnt;
    do_start(1'b0);
    for (int i = 0; i < 11; i++) begin
      send_byte(1'b0, bq[i], ok);
      all_ok &= ok;
    end
    wait_done(1'b0, ok);
    all_ok &= ok;
    compared++;
    if (!all_ok) begin
      mismatched++;
      $display("FAIL reload_handshake: got timeout expected completion");
    end
    compared++;
    if (setup_cnt - base != 88 || chain !== expv) begin
      mismatched++;
      $display("FAIL reload_chain: got %0d/%h expected 88/%h", setup_cnt - base, chain, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_full_load;
    test_partial;
    test_backpressure;
    test_ignore_busy;
    test_reset_reload;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
